// File: rtl/dco_control.sv
// DCO: synthesises a 50 % duty generated clock from a signed control code.
// Optional sigma-delta fractional dithering is enabled with `define DCO_DITHER_EN.
module dco_control #(
   parameter int CC_WIDTH     = 9,
   parameter int CNT_WIDTH    = 8,
   parameter int NOMINAL_HALF = 40,
   parameter int GAIN_SHIFT   = 3,
   parameter int HALF_MIN     = 4,
   parameter int HALF_MAX     = 255
) (
   input  logic                 fpga_clk_i,
   input  logic                 reset_ni,
   input  logic                 enable_i,
   input  logic [CC_WIDTH-1:0]  dco_cc_i,
   output logic                 gen_clk_o,
   output logic [CNT_WIDTH-1:0] half_period_o,
   output logic                 cc_update_o,
   output logic                 saturated_o
);

   localparam int RW = CNT_WIDTH + 2;
   localparam logic signed [RW-1:0] NOM_S = RW'(NOMINAL_HALF);
   localparam logic signed [RW-1:0] MIN_S = RW'(HALF_MIN);
   localparam logic signed [RW-1:0] MAX_S = RW'(HALF_MAX);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] half_q, half_d;
   logic                 gen_q, gen_d;
   logic                 upd_q, upd_d;
   logic                 sat_q, sat_d;
   logic                 latch;
   logic                 carry;

   logic signed [CC_WIDTH-1:0] cc_s, cc_fl;
   logic signed [RW-1:0]       cc_shr, carry_s, raw;
   logic [CNT_WIDTH-1:0]       half_calc;
   logic                       sat_calc;

   assign cc_s    = dco_cc_i;
   assign cc_fl   = cc_s >>> GAIN_SHIFT;
   assign cc_shr  = RW'(cc_fl);
   assign carry_s = {{(RW-1){1'b0}}, carry};
   assign raw     = NOM_S - cc_shr - carry_s;

   always_comb begin
      sat_calc = (raw < MIN_S) || (raw > MAX_S);
      if (raw < MIN_S)      half_calc = CNT_WIDTH'(HALF_MIN);
      else if (raw > MAX_S) half_calc = CNT_WIDTH'(HALF_MAX);
      else                  half_calc = raw[CNT_WIDTH-1:0];
   end

`ifdef DCO_DITHER_EN
   if (GAIN_SHIFT > 0) begin : g_dither
      logic [GAIN_SHIFT-1:0] acc_q, acc_d;
      logic [GAIN_SHIFT:0]   sum;
      // Low bits of cc are the remainder discarded by the floor shift.
      assign sum   = {1'b0, acc_q} + {1'b0, dco_cc_i[GAIN_SHIFT-1:0]};
      assign carry = sum[GAIN_SHIFT];
      assign acc_d = latch ? sum[GAIN_SHIFT-1:0] : acc_q;
      always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
         if (!reset_ni) acc_q <= '0;
         else           acc_q <= acc_d;
      end
   end else begin : g_no_dither
      assign carry = 1'b0;
   end
`else
   assign carry = 1'b0;
`endif

   always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         half_q  <= CNT_WIDTH'(NOMINAL_HALF);
         gen_q   <= 1'b0;
         upd_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         gen_q   <= gen_d;
         upd_q   <= upd_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      case (state_q)
         IDLE: if (enable_i) begin
            latch   = 1'b1;
            state_d = HIGH;
         end
         HIGH: if (cnt_q == '0) state_d = LOW;
         LOW: if (cnt_q == '0) begin
            if (enable_i) begin
               latch   = 1'b1;
               state_d = HIGH;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      gen_d  = gen_q;
      sat_d  = sat_q;
      upd_d  = 1'b0;
      if (latch) begin
         half_d = half_calc;
         sat_d  = sat_calc;
         cnt_d  = half_calc - CNT_WIDTH'(1);
         gen_d  = 1'b1;
         upd_d  = 1'b1;
      end else begin
         case (state_q)
            HIGH: if (cnt_q == '0) begin
               gen_d = 1'b0;
               cnt_d = half_q - CNT_WIDTH'(1);
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            LOW: if (cnt_q == '0) gen_d = 1'b0;
                 else             cnt_d = cnt_q - CNT_WIDTH'(1);
            default: gen_d = 1'b0;
         endcase
      end
   end

   assign gen_clk_o     = gen_q;
   assign half_period_o = half_q;
   assign cc_update_o   = upd_q;
   assign saturated_o   = sat_q;

endmodule

// File: tb/tb_dco_control.sv
// Directed self-checking bench for dco_control (default and GAIN_SHIFT=0 builds).
module tb_dco_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, en1;
   logic [8:0] cc, cc1;
   logic       gen, upd, sat, gen1, upd1, sat1;
   logic [7:0] half, half1;

   int n_tests = 0;
   int n_fail  = 0;
   int hi, lo, up, zeros, sum;
   int exp4[4];

   always #5 clk = ~clk;

   dco_control u_dut (
      .fpga_clk_i(clk), .reset_ni(rst_n), .enable_i(en), .dco_cc_i(cc),
      .gen_clk_o(gen), .half_period_o(half), .cc_update_o(upd), .saturated_o(sat)
   );

   dco_control #(.GAIN_SHIFT(0)) u_gs0 (
      .fpga_clk_i(clk), .reset_ni(rst_n), .enable_i(en1), .dco_cc_i(cc1),
      .gen_clk_o(gen1), .half_period_o(half1), .cc_update_o(upd1), .saturated_o(sat1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Entered on the sample where gen has just risen; leaves on the next rise.
   task automatic measure(input int chg_at, input logic [8:0] chg_val,
                          output int h, output int l, output int u);
      h = 0; l = 0; u = 0;
      while (gen === 1'b1 && h < 600) begin
         if (h == chg_at) cc = chg_val;
         u += int'(upd);
         h++;
         @(negedge clk);
      end
      while (gen === 1'b0 && l < 600) begin
         u += int'(upd);
         l++;
         @(negedge clk);
      end
   endtask

   initial begin
`ifdef DCO_DITHER_EN
      exp4 = '{40, 39, 40, 39};
`else
      exp4 = '{40, 40, 40, 40};
`endif
      rst_n = 1'b0; en = 1'b0; cc = 9'd0; en1 = 1'b0; cc1 = 9'd0;
      repeat (2) @(negedge clk);
      chk("rst_gen",  32'(gen),  0);
      chk("rst_half", 32'(half), 40);
      chk("rst_upd",  32'(upd),  0);
      chk("rst_sat",  32'(sat),  0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_gen", 32'(gen), 0);

      // GAIN_SHIFT=0 instance: clamp at both ends
      en1 = 1'b1; cc1 = 9'd100;
      @(negedge clk);
      chk("gs0_gen",     32'(gen1),  1);
      chk("gs0_upd",     32'(upd1),  1);
      chk("gs0_lo_half", 32'(half1), 4);
      chk("gs0_lo_sat",  32'(sat1),  1);
      cc1 = 9'h100;
      repeat (8) @(negedge clk);
      chk("gs0_rise2",   32'(upd1),  1);
      chk("gs0_hi_half", 32'(half1), 255);
      chk("gs0_hi_sat",  32'(sat1),  1);
      cc1 = 9'd0;
      repeat (510) @(negedge clk);
      chk("gs0_rise3",   32'(upd1),  1);
      chk("gs0_nom",     32'(half1), 40);
      chk("gs0_nom_sat", 32'(sat1),  0);
      en1 = 1'b0;

      // Nominal run, one-cycle latency
      en = 1'b1;
      @(negedge clk);
      chk("lat_gen",  32'(gen),  1);
      chk("lat_upd",  32'(upd),  1);
      chk("lat_half", 32'(half), 40);
      chk("lat_sat",  32'(sat),  0);
      for (int i = 0; i < 2; i++) begin
         measure(-1, 9'd0, hi, lo, up);
         chk("nom_hi",  hi, 40);
         chk("nom_lo",  lo, 40);
         chk("nom_upd", up, 1);
      end

      // Mid-HIGH cc changes take effect at the next rise only
      measure(10, 9'd80, hi, lo, up);
      chk("cc80_cur_hi", hi, 40);
      chk("cc80_cur_lo", lo, 40);
      chk("cc80_half", 32'(half), 30);
      measure(10, 9'h100, hi, lo, up);
      chk("cc80_hi", hi, 30);
      chk("cc80_lo", lo, 30);
      chk("ccm256_half", 32'(half), 72);
      chk("ccm256_sat",  32'(sat),  0);
      measure(5, 9'd0, hi, lo, up);
      chk("ccm256_hi", hi, 72);
      chk("ccm256_lo", lo, 72);
      chk("back_half", 32'(half), 40);

      // Disable 5 cycles into HIGH, re-enable mid-LOW: period completes and continues
      repeat (4) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      hi = 0;
      while (gen === 1'b1 && hi < 600) begin hi++; @(negedge clk); end
      chk("dis_rest_hi", hi, 35);
      lo = 0;
      while (gen === 1'b0 && lo < 600) begin
         if (lo == 20) en = 1'b1;
         lo++;
         @(negedge clk);
      end
      chk("dis_lo", lo, 40);
      chk("reen_upd", 32'(upd), 1);

      // Disable for good: full period, then IDLE, restart latency 1
      en = 1'b0;
      hi = 0;
      while (gen === 1'b1 && hi < 600) begin hi++; @(negedge clk); end
      chk("stop_hi", hi, 40);
      zeros = 0;
      repeat (60) begin
         if (gen === 1'b0 && upd === 1'b0) zeros++;
         @(negedge clk);
      end
      chk("idle_quiet", zeros, 60);
      en = 1'b1;
      @(negedge clk);
      chk("restart_gen", 32'(gen), 1);
      chk("restart_upd", 32'(upd), 1);

      // Asynchronous reset mid-LOW
      cc = 9'd80;
      measure(-1, 9'd0, hi, lo, up);
      chk("pre_rst_half", 32'(half), 30);
      repeat (40) @(negedge clk);
      chk("mid_low_gen", 32'(gen), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gen",  32'(gen),  0);
      chk("arst_half", 32'(half), 40);
      chk("arst_upd",  32'(upd),  0);
      chk("arst_sat",  32'(sat),  0);
      chk("arst_half1", 32'(half1), 40);
      en = 1'b0; cc = 9'd0;
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_gen", 32'(gen), 0);
      en = 1'b1;
      @(negedge clk);
      chk("post_rst_rise", 32'(gen), 1);
      chk("post_rst_half", 32'(half), 40);

      // Fractional code: dithered or constant depending on build
      cc = 9'd4;
      measure(-1, 9'd0, hi, lo, up);
      chk("frac_cur_hi", hi, 40);
      for (int i = 0; i < 4; i++) begin
         chk("frac4_half", 32'(half), 32'(exp4[i]));
         if (i == 3) cc = 9'd1;
         measure(-1, 9'd0, hi, lo, up);
         chk("frac4_hi", hi, exp4[i]);
         chk("frac4_lo", lo, exp4[i]);
      end
      sum = 0;
      for (int j = 0; j < 8; j++) begin
         sum += int'(half);
         measure(-1, 9'd0, hi, lo, up);
         chk("frac1_hilo", hi, lo);
      end
`ifdef DCO_DITHER_EN
      chk("frac1_sum", sum, 319);
`else
      chk("frac1_sum", sum, 320);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
